// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: multicycle fetch/PC sequencer for the RV32 core.
// Owns the architectural PC, issues instruction-memory reads, hands each word to decode
// over a valid/ready handshake, then waits for the branch unit to pick the next PC.
// Optional feature: define FETCH_TIMEOUT_EN to trap when IMEM_ACK does not arrive
// within MAX_WAIT request cycles. Without it, REQ waits forever and ERR[1] is tied low.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTR,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  input  logic        BR_VALID,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  output logic [31:0] PC,
  output logic        FLUSH,
  output logic [31:0] RETIRED,
  output logic [1:0]  ERR
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StHold,
    StResolve,
    StTrap
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        flush_q, flush_d;
  logic        err_mis_q, err_mis_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_to_q, err_to_d;
  logic            timeout;

  // Counter sits at zero outside REQ, so every entry into REQ starts a fresh count.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == StReq && !IMEM_ACK) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // This cycle is the MAX_WAIT-th REQ cycle and it still has no ACK.
  assign timeout = (wait_cnt_q == CntW'(MAX_WAIT - 1)) && !IMEM_ACK;

  // Timeout state and sticky error bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_q <= '0;
      err_to_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_to_q   <= err_to_d;
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MAX_WAIT;
`endif

  // Next-state, PC commit, instruction latch and error tracking.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    flush_d   = 1'b0;
    err_mis_d = err_mis_q;
`ifdef FETCH_TIMEOUT_EN
    err_to_d  = err_to_q;
`endif
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (IMEM_ACK) begin
          instr_d = IMEM_RDATA;
          state_d = StHold;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (timeout) begin
          err_to_d = 1'b1;
          state_d  = StTrap;
        end
`endif
      end
      StHold: begin
        if (INSTR_READY) begin
          state_d = StResolve;
        end
      end
      StResolve: begin
        if (BR_VALID) begin
          if (!BR_TAKEN) begin
            pc_d      = pc_q + 32'd4;
            retired_d = retired_q + 32'd1;
            state_d   = StReq;
          end else if (BR_TARGET[1:0] != 2'b00) begin
            // Misaligned redirect: leave PC and RETIRED alone and park.
            err_mis_d = 1'b1;
            state_d   = StTrap;
          end else begin
            pc_d      = BR_TARGET;
            flush_d   = 1'b1;
            retired_d = retired_q + 32'd1;
            state_d   = StReq;
          end
        end
      end
      StTrap: state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  // Architectural state; synchronous reset wins in every state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      pc_q      <= RESET_VECTOR;
      instr_q   <= 32'd0;
      retired_q <= 32'd0;
      flush_q   <= 1'b0;
      err_mis_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      flush_q   <= flush_d;
      err_mis_q <= err_mis_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    IMEM_REQ    = (state_q == StReq);
    IMEM_ADDR   = pc_q;
    INSTR       = instr_q;
    INSTR_VALID = (state_q == StHold);
    PC          = pc_q;
    FLUSH       = flush_q;
    RETIRED     = retired_q;
`ifdef FETCH_TIMEOUT_EN
    ERR         = {err_to_q, err_mis_q};
`else
    ERR         = {1'b0, err_mis_q};
`endif
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: plays instruction memory, decode and branch unit.
// Expected fetch addresses and instruction words are queued as stimulus is driven
// and popped when the DUT presents the matching fetch or decode handshake.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic        BR_VALID;
  logic        BR_TAKEN;
  logic [31:0] BR_TARGET;
  logic [31:0] PC;
  logic        FLUSH;
  logic [31:0] RETIRED;
  logic [1:0]  ERR;

  pc_fetch_ctrl #(
    .RESET_VECTOR(RV),
    .MAX_WAIT    (15)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IMEM_REQ   (IMEM_REQ),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_ACK   (IMEM_ACK),
    .IMEM_RDATA (IMEM_RDATA),
    .INSTR      (INSTR),
    .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY),
    .BR_VALID   (BR_VALID),
    .BR_TAKEN   (BR_TAKEN),
    .BR_TARGET  (BR_TARGET),
    .PC         (PC),
    .FLUSH      (FLUSH),
    .RETIRED    (RETIRED),
    .ERR        (ERR)
  );

  always #5 CLK = ~CLK;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] addr_exp_q[$];
  logic [31:0] instr_exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;
  logic [1:0]  exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20 && IMEM_REQ !== 1'b1; i++) @(negedge CLK);
    check_eq("req_seen", {31'd0, IMEM_REQ}, 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    IMEM_ACK = 1'b0;
    INSTR_READY = 1'b0;
    BR_VALID = 1'b0;
    BR_TAKEN = 1'b0;
    repeat (2) @(negedge CLK);
    exp_pc  = RV;
    exp_ret = 32'd0;
    exp_err = 2'b00;
    check_eq("rst_pc", PC, RV);
    check_eq("rst_req", {31'd0, IMEM_REQ}, 32'd0);
    check_eq("rst_instr", INSTR, 32'd0);
    check_eq("rst_valid", {31'd0, INSTR_VALID}, 32'd0);
    check_eq("rst_flush", {31'd0, FLUSH}, 32'd0);
    check_eq("rst_retired", RETIRED, 32'd0);
    check_eq("rst_err", {30'd0, ERR}, 32'd0);
    RST = 1'b0;
    addr_exp_q.delete();
    instr_exp_q.delete();
    addr_exp_q.push_back(RV);
  endtask

  // One full instruction: fetch (with ACK delay), decode handshake (with READY delay),
  // then branch resolution. Optional stray BR_VALID pulses while in HOLD must be ignored.
  task automatic do_instr(input int ack_dly, input int rdy_dly, input int br_dly,
                          input logic taken, input logic [31:0] target, input logic stray);
    logic [31:0] a_exp;
    logic [31:0] i_exp;
    logic [31:0] word;
    logic        trap;
    logic        exp_flush;
    wait_req();
    a_exp = (addr_exp_q.size() > 0) ? addr_exp_q.pop_front() : 32'hDEAD_BEEF;
    check_eq("imem_addr", IMEM_ADDR, a_exp);
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge CLK);
      check_eq("addr_stable", IMEM_ADDR, a_exp);
      check_eq("req_held", {31'd0, IMEM_REQ}, 32'd1);
      check_eq("flush_low", {31'd0, FLUSH}, 32'd0);
    end
    word = $urandom;
    IMEM_ACK = 1'b1;
    IMEM_RDATA = word;
    instr_exp_q.push_back(word);
    @(negedge CLK);
    IMEM_ACK = 1'b0;
    IMEM_RDATA = $urandom;
    check_eq("hold_valid", {31'd0, INSTR_VALID}, 32'd1);
    check_eq("hold_req", {31'd0, IMEM_REQ}, 32'd0);
    i_exp = instr_exp_q[0];
    for (int i = 0; i < rdy_dly; i++) begin
      if (stray) begin
        BR_VALID = 1'b1;
        BR_TAKEN = 1'b1;
        BR_TARGET = 32'h0000_0003;
      end
      @(negedge CLK);
      BR_VALID = 1'b0;
      check_eq("instr_stable", INSTR, i_exp);
      check_eq("hold_valid_stall", {31'd0, INSTR_VALID}, 32'd1);
      check_eq("hold_pc", PC, exp_pc);
      check_eq("hold_err", {30'd0, ERR}, {30'd0, exp_err});
    end
    INSTR_READY = 1'b1;
    check_eq("instr", INSTR, instr_exp_q.pop_front());
    @(negedge CLK);
    INSTR_READY = 1'b0;
    check_eq("valid_drop", {31'd0, INSTR_VALID}, 32'd0);
    repeat (br_dly) @(negedge CLK);
    BR_VALID = 1'b1;
    BR_TAKEN = taken;
    BR_TARGET = target;
    trap = taken && (target[1:0] != 2'b00);
    if (trap) begin
      exp_err[0] = 1'b1;
      exp_flush = 1'b0;
    end else begin
      exp_pc = taken ? target : exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
      exp_flush = taken;
      addr_exp_q.push_back(exp_pc);
    end
    @(negedge CLK);
    BR_VALID = 1'b0;
    BR_TAKEN = 1'b0;
    check_eq("flush", {31'd0, FLUSH}, {31'd0, exp_flush});
    check_eq("pc", PC, exp_pc);
    check_eq("retired", RETIRED, exp_ret);
    check_eq("err", {30'd0, ERR}, {30'd0, exp_err});
    check_eq("req_after_br", {31'd0, IMEM_REQ}, {31'd0, !trap});
  endtask

  initial begin
    int req_hi;
    RST = 1'b1;
    IMEM_ACK = 1'b0;
    IMEM_RDATA = 32'd0;
    INSTR_READY = 1'b0;
    BR_VALID = 1'b0;
    BR_TAKEN = 1'b0;
    BR_TARGET = 32'd0;

    do_reset();
    check_eq("idle_no_req", {31'd0, IMEM_REQ}, 32'd0);
    @(negedge CLK);
    check_eq("req_after_rst", {31'd0, IMEM_REQ}, 32'd1);

    // Straight-line code: 0x100, 0x104, 0x108, RETIRED=3, no flush.
    for (int i = 0; i < 3; i++) do_instr(0, 0, 0, 1'b0, 32'd0, 1'b0);

    // Taken redirect, then PC+4 wrap from the top of the address space.
    do_instr(0, 0, 1, 1'b1, 32'h0000_0200, 1'b0);
    do_instr(1, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    do_instr(0, 0, 0, 1'b0, 32'd0, 1'b0);
    do_instr(0, 0, 0, 1'b0, 32'd0, 1'b0);

    // Slow memory and slow decode, with stray branch strobes during HOLD.
    do_instr(5, 3, 2, 1'b0, 32'd0, 1'b1);

`ifdef FETCH_TIMEOUT_EN
    wait_req();
    repeat (14) @(negedge CLK);
    check_eq("to_not_yet_req", {31'd0, IMEM_REQ}, 32'd1);
    check_eq("to_not_yet_err", {30'd0, ERR}, 32'd0);
    @(negedge CLK);
    check_eq("to_err", {30'd0, ERR}, 32'd2);
    check_eq("to_trap_req", {31'd0, IMEM_REQ}, 32'd0);
    do_reset();
    do_instr(14, 0, 0, 1'b0, 32'd0, 1'b0);
`else
    wait_req();
    repeat (20) @(negedge CLK);
    check_eq("long_wait_req", {31'd0, IMEM_REQ}, 32'd1);
    check_eq("long_wait_err", {30'd0, ERR}, 32'd0);
    do_instr(0, 0, 0, 1'b0, 32'd0, 1'b0);
`endif

    // Misaligned taken target traps and stays parked.
    do_instr(0, 1, 0, 1'b1, 32'h0000_0202, 1'b0);
    req_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) req_hi++;
    end
    check_eq("trap_quiet_cycles", req_hi, 32'd0);
    check_eq("trap_err", {30'd0, ERR}, 32'd1);
    check_eq("trap_pc", PC, exp_pc);
    check_eq("trap_retired", RETIRED, exp_ret);

    // Reset recovers from TRAP.
    do_reset();
    do_instr(0, 0, 0, 1'b0, 32'd0, 1'b0);

    // Reset in the middle of a request aborts the fetch.
    wait_req();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("midreq_rst_req", {31'd0, IMEM_REQ}, 32'd0);
    check_eq("midreq_rst_pc", PC, RV);
    check_eq("midreq_rst_retired", RETIRED, 32'd0);
    do_reset();
    do_instr(0, 0, 0, 1'b1, 32'h0000_0040, 1'b0);
    do_instr(0, 0, 0, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
